// File: rtl/kanji_multi_if.sv
// CPU I/O bus and arbiter memory port of the multi-level kanji font ROM block.
interface kanji_multi_if;
  logic        cs;
  logic        cpu_iorq;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  addr;
  logic [7:0]  din;
  logic [7:0]  cpu_dout;
  logic        cpu_dout_valid;
  logic [26:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_din;

  modport slave (
    input  cs, cpu_iorq, cpu_rd, cpu_wr, addr, din, mem_ack, mem_din,
    output cpu_dout, cpu_dout_valid, mem_addr, mem_rd
  );

  modport master (
    output cs, cpu_iorq, cpu_rd, cpu_wr, addr, din, mem_ack, mem_din,
    input  cpu_dout, cpu_dout_valid, mem_addr, mem_rd
  );
endinterface

// File: rtl/kanji_multi.sv
// Multi-level kanji font port: per-level glyph address, one-byte prefetch, shared memory requester.
// Define KANJI_READBACK_EN to make even-port reads return the level's column register.
module kanji_multi #(
  parameter int unsigned LEVELS         = 2,
  parameter logic [7:0]  IO_BASE        = 8'hD8,
  parameter logic [26:0] LEVEL_STRIDE   = 27'h20000,
  parameter int unsigned LEVEL_KB_UNITS = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [26:0]   base_ram,
  input  logic [15:0]   rom_size,
  kanji_multi_if.slave  bus
);

  localparam int unsigned LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef logic [LW-1:0] lvl_t;
  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e      state_q, state_d;
  logic        mem_rd_q, mem_rd_d;
  logic [26:0] mem_addr_q, mem_addr_d;
  lvl_t        req_lvl_q, req_lvl_d;
  logic        stale_q, stale_d;
  logic        wait_q, wait_d;
  lvl_t        wait_lvl_q, wait_lvl_d;
  logic [7:0]  dout_q, dout_d;
  logic        dvalid_q, dvalid_d;

  logic [5:0]  col_q [LEVELS];
  logic [5:0]  col_d [LEVELS];
  logic [5:0]  row_q [LEVELS];
  logic [5:0]  row_d [LEVELS];
  logic [4:0]  cnt_q [LEVELS];
  logic [4:0]  cnt_d [LEVELS];
  logic [7:0]  buf_q [LEVELS];
  logic        buf_we;
  logic [LEVELS-1:0] valid_q, valid_d;
  logic [LEVELS-1:0] pend_q, pend_d;
  logic [LEVELS-1:0] en;

  logic [7:0]  port_off;
  logic        hit, is_odd, wr_hit, rd_hit;
  lvl_t        acc_lvl;
  logic        pick_ok;
  lvl_t        pick_lvl;
  logic [26:0] pick_addr;
  logic        wr_inflight, ack_ok, ack_for_wait, ack_for_rd, rd_odd_en;
  logic        unused_din;

  assign unused_din = ^bus.din[7:6];

  // Port decode; alignment of IO_BASE makes bit 0 the even/odd select.
  assign port_off = bus.addr - IO_BASE;
  assign hit      = bus.cs && bus.cpu_iorq && (bus.addr >= IO_BASE)
                    && (port_off < 8'(2 * LEVELS));
  assign is_odd   = port_off[0];
  assign acc_lvl  = port_off[LW:1];
  assign wr_hit   = hit && bus.cpu_wr;
  assign rd_hit   = hit && bus.cpu_rd && !bus.cpu_wr;

  always_comb begin
    for (int n = 0; n < LEVELS; n++) begin
      en[n] = 32'(rom_size) >= LEVEL_KB_UNITS * (n + 1);
    end
  end

  // Lowest-numbered enabled level with a pending prefetch wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_lvl = '0;
    for (int n = LEVELS - 1; n >= 0; n--) begin
      if (pend_q[n] && en[n]) begin
        pick_ok  = 1'b1;
        pick_lvl = lvl_t'(n);
      end
    end
  end

  assign pick_addr = base_ram + (27'(pick_lvl) * LEVEL_STRIDE)
                     + 27'({row_q[pick_lvl], col_q[pick_lvl], cnt_q[pick_lvl]});

  assign wr_inflight  = wr_hit && (acc_lvl == req_lvl_q);
  assign ack_ok       = (state_q == S_REQ) && bus.mem_ack && !stale_q && !wr_inflight;
  assign rd_odd_en    = rd_hit && !wait_q && is_odd && en[acc_lvl];
  assign ack_for_wait = ack_ok && wait_q && (wait_lvl_q == req_lvl_q);
  // A read landing on the very cycle its own prefetch is acked is served straight from mem_din.
  assign ack_for_rd   = ack_ok && rd_odd_en && !valid_q[acc_lvl] && (acc_lvl == req_lvl_q);

  // NOTE: every variable gets its hold/default value first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    req_lvl_d  = req_lvl_q;
    stale_d    = stale_q;
    wait_d     = wait_q;
    wait_lvl_d = wait_lvl_q;
    dout_d     = dout_q;
    dvalid_d   = 1'b0;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    buf_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          state_d    = S_REQ;
          mem_rd_d   = 1'b1;
          mem_addr_d = pick_addr;
          req_lvl_d  = pick_lvl;
          // A same-cycle write means the latched address already predates it.
          stale_d    = wr_hit && (acc_lvl == pick_lvl);
        end
      end
      S_REQ: begin
        if (wr_inflight) stale_d = 1'b1;
        if (bus.mem_ack) begin
          state_d  = S_IDLE;
          mem_rd_d = 1'b0;
          if (ack_ok && !ack_for_wait && !ack_for_rd) begin
            buf_we              = 1'b1;
            valid_d[req_lvl_q]  = 1'b1;
            pend_d[req_lvl_q]   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_hit) begin
      if (is_odd) row_d[acc_lvl] = bus.din[5:0];
      else        col_d[acc_lvl] = bus.din[5:0];
      cnt_d[acc_lvl]   = '0;
      valid_d[acc_lvl] = 1'b0;
      pend_d[acc_lvl]  = en[acc_lvl];
    end else if (rd_hit && !wait_q) begin
      dvalid_d = 1'b1;
      dout_d   = 8'hFF;
      if (rd_odd_en) begin
        if (valid_q[acc_lvl]) begin
          dout_d           = buf_q[acc_lvl];
          cnt_d[acc_lvl]   = cnt_q[acc_lvl] + 5'd1;
          valid_d[acc_lvl] = 1'b0;
          pend_d[acc_lvl]  = 1'b1;
        end else if (ack_for_rd) begin
          dout_d          = bus.mem_din;
          cnt_d[acc_lvl]  = cnt_q[acc_lvl] + 5'd1;
          pend_d[acc_lvl] = 1'b1;
        end else begin
          dvalid_d   = 1'b0;
          dout_d     = dout_q;
          wait_d     = 1'b1;
          wait_lvl_d = acc_lvl;
        end
      end else if (!is_odd) begin
`ifdef KANJI_READBACK_EN
        dout_d = {2'b00, col_q[acc_lvl]};
`else
        dout_d = 8'hFF;
`endif
      end
    end

    if (ack_for_wait) begin
      dvalid_d           = 1'b1;
      dout_d             = bus.mem_din;
      cnt_d[wait_lvl_q]  = cnt_q[wait_lvl_q] + 5'd1;
      pend_d[wait_lvl_q] = 1'b1;
      wait_d             = 1'b0;
    end else if (wait_q && !en[wait_lvl_q]
                 && !((state_q == S_REQ) && (req_lvl_q == wait_lvl_q))) begin
      // Level was disabled under a waiting read: release it as a disabled-level read.
      dvalid_d = 1'b1;
      dout_d   = 8'hFF;
      wait_d   = 1'b0;
    end

    pend_d = pend_d & en;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      req_lvl_q  <= '0;
      stale_q    <= 1'b0;
      wait_q     <= 1'b0;
      wait_lvl_q <= '0;
      dout_q     <= 8'hFF;
      dvalid_q   <= 1'b0;
      valid_q    <= '0;
      pend_q     <= '0;
      for (int n = 0; n < LEVELS; n++) begin
        col_q[n] <= '0;
        row_q[n] <= '0;
        cnt_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      req_lvl_q  <= req_lvl_d;
      stale_q    <= stale_d;
      wait_q     <= wait_d;
      wait_lvl_q <= wait_lvl_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: the prefetch buffers carry no reset; they are only read while their valid bit is set.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[req_lvl_q] <= bus.mem_din;
  end

  assign bus.cpu_dout       = dout_q;
  assign bus.cpu_dout_valid = dvalid_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_rd         = mem_rd_q;

endmodule
